// File: rtl/spi_cmd_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_cmd_ctrl_if : byte-stream and memory-port bundle for spi_cmd_ctrl    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              busy;
  logic [7:0]        in_byte;
  logic [7:0]        out_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              frame_active;
  logic              cmd_err;

  // master: the command controller; slave: SPI byte engine plus memory
  modport master (
    input  busy, in_byte, mem_rdata,
    output out_byte, mem_addr, mem_wdata, mem_we, mem_re, frame_active, cmd_err
  );
  modport slave (
    output busy, in_byte, mem_rdata,
    input  out_byte, mem_addr, mem_wdata, mem_we, mem_re, frame_active, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_cmd_ctrl : SPI byte-stream command decoder driving a memory port.    |
// | Optional macro SPI_CMD_STATUS_EN adds command 0x03 (status readback).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 16
) (
  input  wire logic      clk,
  input  wire logic      rst,
  spi_cmd_ctrl_if.master bus_io
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CMD     = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_WRITE   = 3'd3,
    S_READ    = 3'd4,
    S_DISCARD = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q;
  logic              byte_done;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_cmd_q, rd_cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        out_q, out_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              rd_dly_q;
  logic              err_q, err_d;
`ifdef SPI_CMD_STATUS_EN
  logic              stat_q, stat_d;
  logic              sticky_q, sticky_d;
`endif

  assign byte_done = busy_q & ~bus_io.busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_cmd_d   = rd_cmd_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    out_d      = out_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    err_d      = 1'b0;
`ifdef SPI_CMD_STATUS_EN
    stat_d     = stat_q;
    sticky_d   = sticky_q;
`endif

    if (bus_io.busy) begin
      cnt_d = '0;
    end else if (state_q != S_CMD) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (byte_done) begin
      // A completed byte always beats a coinciding timeout
      cnt_d = '0;
      case (state_q)
        S_CMD: begin
          case (bus_io.in_byte)
            8'h00: state_d = S_CMD;
            8'h01: begin state_d = S_ADDR_HI; rd_cmd_d = 1'b0; end
            8'h02: begin state_d = S_ADDR_HI; rd_cmd_d = 1'b1; end
`ifdef SPI_CMD_STATUS_EN
            8'h03: begin
              state_d  = S_READ;
              stat_d   = 1'b1;
              out_d    = {1'b1, sticky_q, 6'b0};
              sticky_d = 1'b0;
            end
`endif
            default: begin state_d = S_DISCARD; err_d = 1'b1; end
          endcase
        end
        S_ADDR_HI: begin
          addr_d[ADDR_W-1:8] = (ADDR_W-8)'(bus_io.in_byte);
          state_d            = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d[7:0] = bus_io.in_byte;
          if (rd_cmd_q) begin
            state_d    = S_READ;
            mem_addr_d = addr_d;
            re_d       = 1'b1;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          we_d       = 1'b1;
          mem_addr_d = addr_q;
          wdata_d    = bus_io.in_byte;
          addr_d     = addr_q + 1'b1;
        end
        S_READ: begin
`ifdef SPI_CMD_STATUS_EN
          if (stat_q) out_d = {1'b1, sticky_q, 6'b0};
          else
`endif
          begin
            addr_d     = addr_q + 1'b1;
            mem_addr_d = addr_d;
            re_d       = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
      state_d = S_CMD;
      cnt_d   = '0;
    end

    if (state_d != S_READ) out_d = 8'h00;
    // Read data arrives one cycle after the strobe
    if (rd_dly_q && state_d == S_READ) out_d = bus_io.mem_rdata;
`ifdef SPI_CMD_STATUS_EN
    if (state_d != S_READ) stat_d = 1'b0;
    if (err_d) sticky_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CMD;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rd_cmd_q   <= 1'b0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      wdata_q    <= 8'h00;
      out_q      <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rd_dly_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef SPI_CMD_STATUS_EN
      stat_q     <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= bus_io.busy;
      cnt_q      <= cnt_d;
      rd_cmd_q   <= rd_cmd_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      out_q      <= out_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rd_dly_q   <= re_q;
      err_q      <= err_d;
`ifdef SPI_CMD_STATUS_EN
      stat_q     <= stat_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

  assign bus_io.out_byte     = out_q;
  assign bus_io.mem_addr     = mem_addr_q;
  assign bus_io.mem_wdata    = wdata_q;
  assign bus_io.mem_we       = we_q;
  assign bus_io.mem_re       = re_q;
  assign bus_io.cmd_err      = err_q;
  assign bus_io.frame_active = (state_q != S_CMD);
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_cmd_ctrl : scoreboard bench for spi_cmd_ctrl                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spi_cmd_ctrl;
  localparam int K_WR = 0, K_RD = 1, K_ERR = 2, K_STAT = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  spi_cmd_ctrl_if #(.ADDR_W(16)) bus_if ();

  spi_cmd_ctrl #(.TIMEOUT_CYCLES(64), .ADDR_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, contents = low address byte XOR 0x4A
  always @(posedge clk) begin
    if (bus_if.mem_re) bus_if.mem_rdata <= bus_if.mem_addr[7:0] ^ 8'h4A;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus_if.in_byte = b;
    bus_if.busy    = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus_if.busy = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  int   rd_cnt;
  int   rd_exp;
  int   st_cnt;
  int   st_exp;
  logic prev_busy;
  always @(negedge clk) begin
    exp_t e;
    int   act_kind;
    if (rst) begin
      rd_cnt    = 0;
      st_cnt    = 0;
      prev_busy = 1'b0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt = rd_cnt - 1;
        if (rd_cnt == 0) check("read_out_byte", int'(bus_if.out_byte), rd_exp);
      end
      if (st_cnt > 0) begin
        st_cnt = st_cnt - 1;
        if (st_cnt == 0) check("status_out_byte", int'(bus_if.out_byte), st_exp);
      end
      if (prev_busy && !bus_if.busy && sb.size() > 0 && sb[0].kind == K_STAT) begin
        e      = sb.pop_front();
        st_exp = e.data;
        st_cnt = 1;
      end
      if (bus_if.mem_we || bus_if.mem_re || bus_if.cmd_err) begin
        check("we_re_exclusive", int'(bus_if.mem_we & bus_if.mem_re), 0);
        act_kind = bus_if.mem_we ? K_WR : (bus_if.mem_re ? K_RD : K_ERR);
        if (sb.size() == 0) begin
          check("unexpected_event_kind", act_kind, -1);
        end else begin
          e = sb.pop_front();
          check("event_kind", act_kind, e.kind);
          if (act_kind == K_WR) begin
            check("write_addr", int'(bus_if.mem_addr), e.addr);
            check("write_data", int'(bus_if.mem_wdata), e.data);
          end else if (act_kind == K_RD) begin
            check("read_addr", int'(bus_if.mem_addr), e.addr);
            rd_exp = e.data;
            rd_cnt = 2;
          end
        end
      end
      prev_busy = bus_if.busy;
    end
  end

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus_if.busy    = 1'b0;
    bus_if.in_byte = 8'h00;
    idle(3);
    @(negedge clk);
    check("rst_out_byte", int'(bus_if.out_byte), 0);
    check("rst_mem_addr", int'(bus_if.mem_addr), 0);
    check("rst_mem_we", int'(bus_if.mem_we), 0);
    check("rst_mem_re", int'(bus_if.mem_re), 0);
    check("rst_cmd_err", int'(bus_if.cmd_err), 0);
    check("rst_frame_active", int'(bus_if.frame_active), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Burst write of two bytes
    push(K_WR, 16'h1234, 8'hAA);
    push(K_WR, 16'h1235, 8'hBB);
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    check("frame_active_mid_write", int'(bus_if.frame_active), 1);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(80);
    check("frame_idle_after_write", int'(bus_if.frame_active), 0);

    // Read with follow-on incrementing read
    push(K_RD, 16'h0010, 8'h5A);
    push(K_RD, 16'h0011, 8'h5B);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00);
    idle(80);
    check("out_byte_zero_after_read", int'(bus_if.out_byte), 0);

    // Address wrap
    push(K_WR, 16'hFFFF, 8'h11);
    push(K_WR, 16'h0000, 8'h22);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22);
    idle(80);

    // Null command stays in CMD
    send_byte(8'h00);
    check("null_cmd_stays_idle", int'(bus_if.frame_active), 0);

    // Unknown command, discard until timeout
    push(K_ERR, 0, 0);
    send_byte(8'h7E);
    idle(50);
    check("discard_before_timeout", int'(bus_if.frame_active), 1);
    idle(20);
    check("discard_after_timeout", int'(bus_if.frame_active), 0);
    push(K_WR, 16'h0000, 8'h33);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h33);
    idle(80);

    // Reset mid-frame aborts it
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("frame_aborted_by_rst", int'(bus_if.frame_active), 0);
    push(K_WR, 16'h0006, 8'h44);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h06); send_byte(8'h44);
    idle(80);

`ifdef SPI_CMD_STATUS_EN
    push(K_ERR, 0, 0);
    send_byte(8'h7E);
    idle(80);
    push(K_STAT, 0, 8'hC0);
    send_byte(8'h03);
    push(K_STAT, 0, 8'h80);
    send_byte(8'h55);
    idle(80);
`else
    push(K_ERR, 0, 0);
    send_byte(8'h03);
    check("cmd03_unknown_discard", int'(bus_if.frame_active), 1);
    idle(80);
`endif

    idle(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
